lmem_port_arbiter: RTL and testbench



---
 rtl/lmem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_lmem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lmem_port_arbiter.sv
// rtl/lmem_port_arbiter.sv - two-requester round-robin arbiter for the layer-memory port
//
// Purpose: shares one layer-memory port between R0 (conv writer) and R1
// (max-pool reader/writer). Round-robin with a per-grant burst limit and a
// lock input. Memory strobes are registered. Read data returns to the
// requester that issued the read, two cycles after the beat was accepted.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   rX_req/we/lock/sel/addr/wdata   requester X beat fields (X = 0, 1)
//   rX_gnt                          requester X owns the port
//   rX_rvalid                       read data valid for requester X
//   rdata                           read data (cdata_rd passthrough)
//   cwr/caddr_wr/cdata_wr           memory write strobe, address, data
//   crd/caddr_rd/cdata_rd           memory read strobe, address, return data
//   csel                            memory select
module lmem_port_arbiter #(
  parameter int AW    = 12,
  parameter int DW    = 20,
  parameter int SW    = 3,
  parameter int BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic          r0_lock,
  input  logic [SW-1:0] r0_sel,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic          r1_lock,
  input  logic [SW-1:0] r1_sel,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] rdata,
  output logic          cwr,
  output logic [AW-1:0] caddr_wr,
  output logic [DW-1:0] cdata_wr,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic [SW-1:0] csel
);

  typedef enum logic [1:0] {NONE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_t;

  localparam logic [3:0] BURST_C = 4'(BURST);

  owner_t        owner_q, owner_d;
  logic          ptr_q, ptr_d;      // 0 favours R0 on a tie, 1 favours R1
  logic [3:0]    cnt_q, cnt_d;
  logic          cwr_q, crd_q;
  logic [AW-1:0] caddr_wr_q, caddr_rd_q;
  logic [DW-1:0] cdata_wr_q;
  logic [SW-1:0] csel_q;
  logic [1:0]    rd_tag_q;          // which requester issued the read now on crd
  logic [1:0]    rvalid_q;

  logic          acc0, acc1, acc;
  logic          acc_we;
  logic [SW-1:0] acc_sel;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [3:0]    cnt_inc, cnt_nxt;
  logic          at_burst;

  assign acc0 = r0_req & (owner_q == OWN0);
  assign acc1 = r1_req & (owner_q == OWN1);
  assign acc  = acc0 | acc1;

  assign acc_we    = acc1 ? r1_we    : r0_we;
  assign acc_sel   = acc1 ? r1_sel   : r0_sel;
  assign acc_addr  = acc1 ? r1_addr  : r0_addr;
  assign acc_wdata = acc1 ? r1_wdata : r0_wdata;

  // Count including this cycle's beat, so the limit is judged on the beat
  // that reaches it and the handoff lands on the very next edge.
  assign cnt_inc  = (cnt_q == BURST_C) ? cnt_q : 4'(cnt_q + 4'd1);
  assign cnt_nxt  = acc ? cnt_inc : cnt_q;
  assign at_burst = (cnt_nxt == BURST_C);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= NONE;
      ptr_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (owner_q)
      NONE: begin
        if (r0_req && r1_req) owner_d = ptr_q ? OWN1 : OWN0;
        else if (r0_req)      owner_d = OWN0;
        else if (r1_req)      owner_d = OWN1;
      end
      OWN0: begin
        if (!r0_req || (r1_req && at_burst && !r0_lock)) begin
          owner_d = r1_req ? OWN1 : NONE;
          ptr_d   = 1'b1;
        end
      end
      OWN1: begin
        if (!r1_req || (r0_req && at_burst && !r1_lock)) begin
          owner_d = r0_req ? OWN0 : NONE;
          ptr_d   = 1'b0;
        end
      end
      default: owner_d = NONE;
    endcase
    cnt_d = (owner_d != owner_q) ? 4'd0 : cnt_nxt;
  end

  // Output decode from registered state only
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (owner_q == OWN0) r0_gnt = 1'b1;
    if (owner_q == OWN1) r1_gnt = 1'b1;
  end

  // Memory-side pipeline: strobe one cycle after accept, rvalid one after that.
  always_ff @(posedge clk) begin
    if (reset) begin
      cwr_q      <= 1'b0;
      crd_q      <= 1'b0;
      caddr_wr_q <= '0;
      caddr_rd_q <= '0;
      cdata_wr_q <= '0;
      csel_q     <= '0;
      rd_tag_q   <= 2'b00;
      rvalid_q   <= 2'b00;
    end else begin
      cwr_q    <= acc & acc_we;
      crd_q    <= acc & ~acc_we;
      rd_tag_q <= {acc1 & ~r1_we, acc0 & ~r0_we};
      rvalid_q <= rd_tag_q;
      if (acc) begin
        csel_q <= acc_sel;
        if (acc_we) begin
          caddr_wr_q <= acc_addr;
          cdata_wr_q <= acc_wdata;
        end else begin
          caddr_rd_q <= acc_addr;
        end
      end
    end
  end

  assign cwr       = cwr_q;
  assign crd       = crd_q;
  assign caddr_wr  = caddr_wr_q;
  assign caddr_rd  = caddr_rd_q;
  assign cdata_wr  = cdata_wr_q;
  assign csel      = csel_q;
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];
  assign rdata     = cdata_rd;

endmodule

// File: tb/tb_lmem_port_arbiter.sv
// tb/tb_lmem_port_arbiter.sv - self-checking bench for lmem_port_arbiter
module tb_lmem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 20;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          r0_req, r0_we, r0_lock;
  logic [SW-1:0] r0_sel;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_gnt, r0_rvalid;
  logic          r1_req, r1_we, r1_lock;
  logic [SW-1:0] r1_sel;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_gnt, r1_rvalid;
  logic [DW-1:0] rdata;
  logic          cwr, crd;
  logic [AW-1:0] caddr_wr, caddr_rd;
  logic [DW-1:0] cdata_wr;
  logic [DW-1:0] cdata_rd = '0;
  logic [SW-1:0] csel;
  logic [DW-1:0] mem_ret = 20'h12345;

  int tests  = 0;
  int failed = 0;

  lmem_port_arbiter #(.AW(AW), .DW(DW), .SW(SW), .BURST(4)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_sel(r0_sel),
    .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_sel(r1_sel),
    .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
  );

  always #5 clk = ~clk;

  // Memory model: data appears the cycle after the read strobe.
  always @(posedge clk) if (crd) cdata_rd <= mem_ret;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Both strobes must never be high together.
  always @(negedge clk) if (!reset) chk("no_cwr_and_crd", 32'(cwr & crd), 32'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_req = 0; r0_we = 0; r0_lock = 0; r0_sel = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_lock = 0; r1_sel = 0; r1_addr = 0; r1_wdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
  endtask

  typedef struct {
    logic          r0_req, r0_we, r1_req, r1_we;
    logic          g0, g1, cwr, crd, rv0, rv1;
    logic [AW-1:0] waddr, raddr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic a, b, c, d, g0, g1, w, r, v0, v1,
                     input logic [AW-1:0] wa, ra);
    vec_t v;
    v.r0_req = a; v.r0_we = b; v.r1_req = c; v.r1_we = d;
    v.g0 = g0; v.g1 = g1; v.cwr = w; v.crd = r; v.rv0 = v0; v.rv1 = v1;
    v.waddr = wa; v.raddr = ra;
    vecs.push_back(v);
  endtask

  initial begin
    reset = 1;
    idle_inputs();

    // Reset state
    do_reset();
    chk("rst_r0_gnt", 32'(r0_gnt), 0);
    chk("rst_r1_gnt", 32'(r1_gnt), 0);
    chk("rst_cwr", 32'(cwr), 0);
    chk("rst_crd", 32'(crd), 0);
    chk("rst_rvalid", 32'({r1_rvalid, r0_rvalid}), 0);
    chk("rst_caddr_wr", 32'(caddr_wr), 0);
    chk("rst_caddr_rd", 32'(caddr_rd), 0);
    chk("rst_cdata_wr", 32'(cdata_wr), 0);
    chk("rst_csel", 32'(csel), 0);

    // Single R0 write beat
    r0_req = 1; r0_we = 1; r0_addr = 12'h005; r0_wdata = 20'h0ABCD; r0_sel = 3'd1;
    tick();
    chk("w1_gnt", 32'(r0_gnt), 1);
    chk("w1_cwr_early", 32'(cwr), 0);
    tick();
    r0_req = 0;
    chk("w1_cwr", 32'(cwr), 1);
    chk("w1_caddr_wr", 32'(caddr_wr), 32'h005);
    chk("w1_cdata_wr", 32'(cdata_wr), 32'h0ABCD);
    chk("w1_csel", 32'(csel), 1);
    chk("w1_crd", 32'(crd), 0);
    tick();
    chk("w1_cwr_off", 32'(cwr), 0);
    chk("w1_addr_hold", 32'(caddr_wr), 32'h005);
    chk("w1_gnt_off", 32'(r0_gnt), 0);

    // Single R1 read beat
    do_reset();
    mem_ret = 20'h12345;
    r1_req = 1; r1_we = 0; r1_addr = 12'h040; r1_sel = 3'd1;
    tick();
    chk("r1_gnt", 32'(r1_gnt), 1);
    tick();
    r1_req = 0;
    chk("r1_crd", 32'(crd), 1);
    chk("r1_caddr_rd", 32'(caddr_rd), 32'h040);
    chk("r1_csel", 32'(csel), 1);
    tick();
    chk("r1_rvalid", 32'(r1_rvalid), 1);
    chk("r1_rdata", 32'(rdata), 32'h12345);
    chk("r1_r0_rvalid", 32'(r0_rvalid), 0);
    chk("r1_crd_off", 32'(crd), 0);

    // Table: round-robin bursts, then reads across a handoff
    add(1,1,1,1, 1,0,0,0,0,0, 12'h000, 12'h000);
    add(1,1,1,1, 1,0,1,0,0,0, 12'h0A0, 12'h000);
    add(1,1,1,1, 1,0,1,0,0,0, 12'h0A0, 12'h000);
    add(1,1,1,1, 1,0,1,0,0,0, 12'h0A0, 12'h000);
    add(1,1,1,1, 0,1,1,0,0,0, 12'h0A0, 12'h000);
    add(1,1,1,1, 0,1,1,0,0,0, 12'h0B1, 12'h000);
    add(1,1,1,1, 0,1,1,0,0,0, 12'h0B1, 12'h000);
    add(1,1,1,1, 0,1,1,0,0,0, 12'h0B1, 12'h000);
    add(1,1,1,1, 1,0,1,0,0,0, 12'h0B1, 12'h000);
    add(1,1,1,1, 1,0,1,0,0,0, 12'h0A0, 12'h000);
    add(0,1,0,1, 0,0,0,0,0,0, 12'h0A0, 12'h000);
    add(1,0,1,0, 0,1,0,0,0,0, 12'h0A0, 12'h000);
    add(0,0,1,0, 0,1,0,1,0,0, 12'h0A0, 12'h0B1);
    add(1,0,0,0, 1,0,0,0,0,1, 12'h0A0, 12'h0B1);
    add(1,0,0,0, 1,0,0,1,0,0, 12'h0A0, 12'h0A0);
    add(0,0,0,0, 0,0,0,0,1,0, 12'h0A0, 12'h0A0);
    add(0,0,0,0, 0,0,0,0,0,0, 12'h0A0, 12'h0A0);
    do_reset();
    r0_addr = 12'h0A0; r0_sel = 3'd2; r0_wdata = 20'h11111;
    r1_addr = 12'h0B1; r1_sel = 3'd5; r1_wdata = 20'h22222;
    foreach (vecs[i]) begin
      r0_req = vecs[i].r0_req; r0_we = vecs[i].r0_we;
      r1_req = vecs[i].r1_req; r1_we = vecs[i].r1_we;
      tick();
      chk($sformatf("v%0d_r0_gnt", i), 32'(r0_gnt), 32'(vecs[i].g0));
      chk($sformatf("v%0d_r1_gnt", i), 32'(r1_gnt), 32'(vecs[i].g1));
      chk($sformatf("v%0d_cwr", i), 32'(cwr), 32'(vecs[i].cwr));
      chk($sformatf("v%0d_crd", i), 32'(crd), 32'(vecs[i].crd));
      chk($sformatf("v%0d_r0_rvalid", i), 32'(r0_rvalid), 32'(vecs[i].rv0));
      chk($sformatf("v%0d_r1_rvalid", i), 32'(r1_rvalid), 32'(vecs[i].rv1));
      chk($sformatf("v%0d_caddr_wr", i), 32'(caddr_wr), 32'(vecs[i].waddr));
      chk($sformatf("v%0d_caddr_rd", i), 32'(caddr_rd), 32'(vecs[i].raddr));
    end

    // Lock holds grant past the burst limit
    do_reset();
    r0_req = 1; r0_we = 1; r0_lock = 1; r0_addr = 12'h010;
    r1_req = 1; r1_we = 1; r1_addr = 12'h020;
    tick();
    chk("lk_first_gnt", 32'(r0_gnt), 1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("lk_beat%0d_gnt", k), 32'({r1_gnt, r0_gnt}), 32'b01);
    end
    r0_req = 0;
    tick();
    chk("lk_handoff_r1", 32'({r1_gnt, r0_gnt}), 32'b10);
    r1_req = 0;
    tick();
    chk("lk_idle", 32'({r1_gnt, r0_gnt}), 32'b00);
    r0_req = 1; r1_req = 1;
    tick();
    chk("lk_tie_r0", 32'({r1_gnt, r0_gnt}), 32'b01);

    // Reset during an R0 read burst
    do_reset();
    r0_req = 1; r0_we = 0; r0_addr = 12'h123;
    tick();
    tick();
    chk("mr_crd_before", 32'(crd), 1);
    reset = 1;
    tick();
    chk("mr_gnt", 32'({r1_gnt, r0_gnt}), 0);
    chk("mr_rvalid", 32'({r1_rvalid, r0_rvalid}), 0);
    chk("mr_crd", 32'(crd), 0);
    chk("mr_cwr", 32'(cwr), 0);
    chk("mr_caddr_rd", 32'(caddr_rd), 0);
    reset = 0;
    r1_req = 1; r1_we = 0;
    tick();
    chk("mr_rearb_r0", 32'({r1_gnt, r0_gnt}), 32'b01);

    idle_inputs();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
